spi_slave: RTL and testbench

Serial front end for the single-port SPI memory. Deserializes 10-bit command frames from MOSI into the memory's parallel command word and pulses `rx_valid` once per frame. For a read-data frame, it waits for the memory's `tx_valid`, captures the 8-bit read byte, and shifts it out on MISO MSB-first. The SPI clock and the system clock are the same signal `clk`; all sampling is on `posedge clk`.

---
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave.sv | 104 ++++++++++
 tb/tb_spi_slave.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bus: serial pins on the master side, parallel command/read-byte
// signals on the memory side.
interface spi_slave_if #(parameter int ADDR_SIZE = 8);
  logic                   ss_n;
  logic                   mosi;
  logic                   miso;
  logic [ADDR_SIZE+1:0]   rx_data;
  logic                   rx_valid;
  logic [ADDR_SIZE-1:0]   tx_data;
  logic                   tx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI front end: deserializes (ADDR_SIZE+2)-bit command frames from MOSI and
// serializes one memory read byte onto MISO per read-data frame.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_if.slave bus
);
  localparam int FW = ADDR_SIZE + 2;
  // Bits shifted after the opcode bit; the 4-bit counter stops here.
  localparam logic [3:0] LAST_CNT = 4'(FW - 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;

  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]        rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_seen_q, rd_addr_seen_d;
  logic [ADDR_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_sent_q, tx_sent_d;
  logic                 miso_q, miso_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_sh_q        <= '0;
      tx_sent_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_sh_q        <= tx_sh_d;
      tx_sent_q      <= tx_sent_d;
      miso_q         <= miso_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_sh_d        = tx_sh_q;
    tx_sent_d      = tx_sent_q;
    miso_d         = 1'b0;

    // Deselect wins over everything: partial frames never raise rx_valid.
    if (state_q != IDLE && bus.ss_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          tx_sh_d   = '0;
          tx_sent_d = 1'b0;
          if (!bus.ss_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          rx_data_d = {rx_data_q[FW-2:0], bus.mosi};
          if (!bus.mosi)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                    state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q < LAST_CNT) begin
            rx_data_d = {rx_data_q[FW-2:0], bus.mosi};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_CNT - 4'd1) begin
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
              if (state_q == READ_DATA) rd_addr_seen_d = 1'b0;
            end
          end else if (state_q == READ_DATA) begin
            // One byte per frame; the register drains to zero after bit 0.
            if (!tx_sent_q && bus.tx_valid) begin
              miso_d    = bus.tx_data[ADDR_SIZE-1];
              tx_sh_d   = {bus.tx_data[ADDR_SIZE-2:0], 1'b0};
              tx_sent_d = 1'b1;
            end else begin
              miso_d  = tx_sh_q[ADDR_SIZE-1];
              tx_sh_d = {tx_sh_q[ADDR_SIZE-2:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of frames with a per-frame memory model, an
// rx_data scoreboard queue, plus a reset-during-MISO sequence.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_if #(.ADDR_SIZE(8)) bus ();
  spi_slave #(.ADDR_SIZE(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [9:0] frame;
    int         abort_at;  // 0: full frame, else bits sent before ss_n rises
    logic [7:0] tx_byte;
    logic       exp_vld;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs [13];
  logic [9:0] rx_q [$];
  int         tests  = 0;
  int         failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance one edge and score any rx_valid pulse against the queue.
  task automatic step();
    logic [9:0] exp;
    @(posedge clk); #1;
    if (bus.rx_valid) begin
      if (rx_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL rx_valid_unexpected: got pulse with rx_data %0h, required none", bus.rx_data);
      end else begin
        exp = rx_q.pop_front();
        chk("rx_data_at_valid", {22'b0, bus.rx_data}, {22'b0, exp});
      end
    end
  endtask

  task automatic send_bits(input logic [9:0] fr, input int nbits);
    bus.ss_n = 1'b0; bus.mosi = 1'b0;
    step();
    for (int i = 9; i > 9 - nbits; i--) begin
      bus.mosi = fr[i];
      step();
    end
    bus.mosi = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] got;
    if (v.abort_at != 0) begin
      send_bits(v.frame, v.abort_at);
      bus.ss_n = 1'b1;
      step();
      chk("miso_after_abort", {31'b0, bus.miso}, 32'd0);
      return;
    end
    rx_q.push_back(v.frame);
    send_bits(v.frame, 10);
    step();
    chk("rx_valid_one_cycle", {31'b0, bus.rx_valid}, 32'd0);
    bus.tx_valid = 1'b1; bus.tx_data = v.tx_byte;
    step();
    bus.tx_valid = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      got[k] = bus.miso;
      step();
    end
    chk("miso_byte", {24'b0, got}, {24'b0, v.exp_miso});
    chk("miso_tail_zero", {31'b0, bus.miso}, 32'd0);
    bus.tx_valid = 1'b1; bus.tx_data = ~v.tx_byte;
    step();
    bus.tx_valid = 1'b0;
    step();
    chk("miso_late_tx_valid", {31'b0, bus.miso}, 32'd0);
    chk("rx_data_hold", {22'b0, bus.rx_data}, {22'b0, v.frame});
    bus.ss_n = 1'b1;
    step();
  endtask

  initial begin
    logic [7:0] rb;
    vecs[0]  = '{10'h005, 0, 8'h3C, 1'b1, 8'h00};
    vecs[1]  = '{10'h1A5, 0, 8'h5A, 1'b1, 8'h00};
    vecs[2]  = '{10'h205, 0, 8'h77, 1'b1, 8'h00};
    vecs[3]  = '{10'h3FF, 0, 8'hA5, 1'b1, 8'hA5};
    vecs[4]  = '{10'h300, 0, 8'h5A, 1'b1, 8'h00};
    vecs[5]  = '{10'h3C3, 0, 8'h5A, 1'b1, 8'h5A};
    vecs[6]  = '{10'h2AA, 6, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{10'h033, 0, 8'h11, 1'b1, 8'h00};
    vecs[8]  = '{10'h381, 0, 8'h22, 1'b1, 8'h00};
    vecs[9]  = '{10'h3FF, 3, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{10'h312, 0, 8'h81, 1'b1, 8'h81};
    vecs[11] = '{10'h155, 9, 8'h00, 1'b0, 8'h00};
    vecs[12] = '{10'h0FF, 0, 8'h44, 1'b1, 8'h00};

    rst_n = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    #12;
    chk("reset_miso", {31'b0, bus.miso}, 32'd0);
    chk("reset_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    chk("reset_rx_data", {22'b0, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 13; n++) run_frame(vecs[n]);

    // Reset while MISO is mid-byte: set up a read address, then a read-data frame.
    run_frame('{10'h211, 0, 8'h00, 1'b1, 8'h00});
    rx_q.push_back(10'h3AA);
    send_bits(10'h3AA, 10);
    step();
    bus.tx_valid = 1'b1; bus.tx_data = 8'hE5;
    step();
    bus.tx_valid = 1'b0;
    for (int k = 7; k >= 5; k--) begin
      rb[k] = bus.miso;
      if (k > 5) step();
    end
    chk("miso_before_reset", {29'b0, rb[7:5]}, 32'd7);
    rst_n = 1'b0; bus.ss_n = 1'b1;
    #1;
    chk("async_reset_miso", {31'b0, bus.miso}, 32'd0);
    chk("async_reset_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    chk("async_reset_rx_data", {22'b0, bus.rx_data}, 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    step();
    run_frame('{10'h3AB, 0, 8'h99, 1'b1, 8'h00});
    run_frame('{10'h3CC, 0, 8'h66, 1'b1, 8'h66});

    chk("rx_queue_drained", rx_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
